// File: rtl/pipe_pkg.sv
// Shared types and stage-width constants for the RV32I pipeline registers.
// Each stage's DATA_W/CTRL_W is derived here so wrappers and the skid stage agree.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REGNUM_W   = 5;
  localparam int unsigned FUNCT_W    = 3;
  localparam int unsigned MEMTOREG_W = 3;

  // MEM_WB payload: PCplus4, BranchAddr, immediate, ReadMemData, ALUResult, funct, WriteRegNum
  localparam int unsigned MEM_WB_DATA_W = 5 * XLEN + FUNCT_W + REGNUM_W;
  // MEM_WB control: cntl_RegWrite, sel_MemToReg
  localparam int unsigned MEM_WB_CTRL_W = 1 + MEMTOREG_W;

  // IF_ID payload: PC, PCplus4, instruction; control: a single predicted-taken flag
  localparam int unsigned IF_ID_DATA_W = 3 * XLEN;
  localparam int unsigned IF_ID_CTRL_W = 1;

  function automatic logic [1:0] occupancy_of(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid) with valid/ready handshake, flush and
// bubble gating so an empty stage never presents live control bits downstream.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = MEM_WB_DATA_W,
  parameter int unsigned CTRL_W         = MEM_WB_CTRL_W,
  parameter bit          FLUSH_CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } entry_t;

  stage_state_e state_q, state_d;
  entry_t       main_q, main_d;
  entry_t       skid_q, skid_d;
  entry_t       in_entry;
  logic         accept;
  logic         drain;

  // Handshake decode; in_ready looks at state only, never at out_ready.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = main_q.valid;
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
    in_entry  = '{data: in_data, ctrl: in_ctrl, valid: 1'b1};
  end

  // Next-state and entry movement; flush overrides any accept or drain.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d      = ST_EMPTY;
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
      if (FLUSH_CLR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d.ctrl = main_q.ctrl;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (drain) begin
            main_d.valid = 1'b0;
            state_d      = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d       = skid_q;
            skid_d.valid = 1'b0;
            state_d      = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_d.valid = 1'b0;
          skid_d.valid = 1'b0;
        end
      endcase
    end
  end

  // State and both entries; reset always clears payload, unlike flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Outputs come straight from registers; ctrl is gated so bubbles stay inert.
  always_comb begin
    out_data  = main_q.data;
    if (main_q.valid) begin
      out_ctrl = main_q.ctrl;
    end else begin
      out_ctrl = '0;
    end
    occupancy = occupancy_of(state_q);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances differing only in whether
// flush clears the payload, both driven from the same stimulus.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [1:0]    occ0, occ1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occ0)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full output view of the clear-on-flush-disabled instance.
  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic [1:0] o, input logic r);
    check({tag, ".valid"}, 64'(out_valid0), 64'(v));
    check({tag, ".data"},  64'(out_data0),  64'(d));
    check({tag, ".ctrl"},  64'(out_ctrl0),  64'(c));
    check({tag, ".occ"},   64'(occ0),       64'(o));
    check({tag, ".ready"}, 64'(in_ready0),  64'(r));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'h0; in_ctrl = 4'h0;
    tick(); tick();
    check_out("rst", 1'b0, 32'h0, 4'h0, 2'd0, 1'b1);
    check("rst.d1", 64'(out_data1), 64'h0);
    reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h100; in_ctrl = 4'h1; tick();
    check_out("s100", 1'b1, 32'h100, 4'h1, 2'd1, 1'b1);
    in_data = 32'h200; in_ctrl = 4'h2; tick();
    check_out("s200", 1'b1, 32'h200, 4'h2, 2'd1, 1'b1);
    in_data = 32'h300; in_ctrl = 4'b1001; tick();
    check_out("s300", 1'b1, 32'h300, 4'b1001, 2'd1, 1'b1);
    in_valid = 1'b0; tick();
    check_out("stale", 1'b0, 32'h300, 4'h0, 2'd0, 1'b1);

    // Back-pressure into the skid entry, then FIFO drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hABCD1234; in_ctrl = 4'b0011; tick();
    check_out("bp1", 1'b1, 32'hABCD1234, 4'b0011, 2'd1, 1'b1);
    in_data = 32'hDEF01234; in_ctrl = 4'b0101; tick();
    check_out("bp2", 1'b1, 32'hABCD1234, 4'b0011, 2'd2, 1'b0);
    in_data = 32'h11111111; in_ctrl = 4'hF; tick();
    check_out("bp3", 1'b1, 32'hABCD1234, 4'b0011, 2'd2, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check_out("dr1", 1'b1, 32'hDEF01234, 4'b0101, 2'd1, 1'b1);
    tick();
    check_out("dr2", 1'b0, 32'hDEF01234, 4'h0, 2'd0, 1'b1);

    // Flush while FULL with a live handshake on both sides
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h56789ABC; in_ctrl = 4'b0010; tick();
    check("fl.pre.d1", 64'(out_data1), 64'h56789ABC);
    in_data = 32'h000000A2; in_ctrl = 4'b0100; tick();
    check_out("fl.full", 1'b1, 32'h56789ABC, 4'b0010, 2'd2, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    in_data = 32'h000000A3; in_ctrl = 4'b1000; tick();
    check_out("fl", 1'b0, 32'h56789ABC, 4'h0, 2'd0, 1'b1);
    check("fl.d1.data", 64'(out_data1), 64'h0);
    check("fl.d1.valid", 64'(out_valid1), 64'h0);
    flush = 1'b0; in_valid = 1'b0; tick();
    check_out("fl.post", 1'b0, 32'h56789ABC, 4'h0, 2'd0, 1'b1);

    // Reset while FULL with a live handshake
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hCAFE0001; in_ctrl = 4'b0111; tick();
    in_data = 32'hCAFE0002; in_ctrl = 4'b0110; tick();
    check_out("rs.full", 1'b1, 32'hCAFE0001, 4'b0111, 2'd2, 1'b0);
    reset = 1'b1; out_ready = 1'b1; tick();
    check_out("rs", 1'b0, 32'h0, 4'h0, 2'd0, 1'b1);
    check("rs.d1.data", 64'(out_data1), 64'h0);

    // Reset and flush together behave as reset
    flush = 1'b1; tick();
    check_out("rsfl", 1'b0, 32'h0, 4'h0, 2'd0, 1'b1);
    reset = 1'b0; flush = 1'b0;

    in_data = 32'h00000077; in_ctrl = 4'b0001; tick();
    check_out("after", 1'b1, 32'h77, 4'b0001, 2'd1, 1'b1);
    check("after.d1", 64'(out_data1), 64'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised two-entry pipeline stage register with valid/ready handshake, stall absorption, flush and bubble gating. It replaces the fixed MEM_WB register and is the generic stage instantiated between every pair of pipeline stages of the RV32I core. It adds back-pressure handling through a skid entry and flush support, and it guarantees that control fields never leak out of an empty stage.

## Interface
Parameters:
- DATA_W, 168, payload width (MEM_WB default: PCplus4, BranchAddr, immediate, ReadMemData, ALUResult, funct, WriteRegNum).
- CTRL_W, 4, control width (MEM_WB default: cntl_RegWrite, sel_MemToReg); forced to 0 when the stage is empty.
- FLUSH_CLR_DATA, 0; when 1, flush and reset also zero the data registers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drops all held entries; takes priority over the handshake.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; equals (state != FULL).
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  main entry present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload.
- out_ctrl  out  CTRL_W  main entry control when out_valid=1, otherwise 0.
- occupancy  out  2  number of entries held (0..2).

## Operation
- Storage: a main register (drives the outputs) and a skid register, each holding {data, ctrl, valid}.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- EMPTY: accept loads main and goes to ONE. Without accept, stays in EMPTY.
- ONE:
  - accept & drain: main loads the input; stays in ONE.
  - accept only: skid loads the input; goes to FULL.
  - drain only: goes to EMPTY.
  - neither: holds.
- FULL: in_ready=0. Drain moves skid into main and goes to ONE. Without drain, holds.
- Order is strictly FIFO: the skid entry always leaves after the main entry.
- Flush: next state is EMPTY regardless of the handshake. An accept or drain in the flush cycle is discarded, and in_ready remains whatever the current state dictates. Data is zeroed only when FLUSH_CLR_DATA=1; otherwise it holds stale values.
- Reset: same as flush, but data and ctrl registers are always zeroed.
- Bubble gating: out_ctrl = out_valid ? main.ctrl : 0. A bubble therefore never asserts RegWrite.
- occupancy is decoded from the state: 0, 1 or 2.

## Timing
- After any clock with reset=1: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
- Latency: an entry accepted at edge N appears on out_* immediately after edge N. It has a 1-cycle register delay.
- Throughput: 1 entry per cycle while out_ready=1, with no bubbles.
- in_ready is a decode of state only, with no combinational path from out_ready. Upstream may therefore see in_ready=1 for one cycle while downstream stalls; the skid entry absorbs that word.
- out_valid, out_data and out_ctrl depend on registers only. out_data is stable while out_valid=1 and out_ready=0.
- reset and flush asserted together behave as reset.
- Reset mid-transfer: any entry in flight is lost and no output toggles.
- Flush for one cycle in FULL: after the edge the stage is EMPTY with in_ready=1.

## Structure
- Package pipe_pkg holds:
  - the state enum (EMPTY/ONE/FULL);
  - MEM_WB field width localparams (XLEN=32, REGNUM_W=5, FUNCT_W=3, MEMTOREG_W=3);
  - the derived DATA_W/CTRL_W constants for each stage.
- No sub-module. The main and skid entries are two instances of the same register logic inside one always block.
- Stage wrappers (e.g. mem_wb_stage) only pack and unpack fields into this block.

## Test plan
- Reset, then stream in 0x100, 0x200, 0x300 with out_ready=1 → out_data shows each value 1 cycle after acceptance, occupancy=1, in_ready never drops.
- Accept 0xABCD1234 with ctrl=4'b0011, then hold out_ready=0 while in_valid=1 with 0xDEF01234 → occupancy=2, in_ready=0, out_data holds 0xABCD1234. Release out_ready → outputs are 0xABCD1234 then 0xDEF01234, in that order.
- FULL state, assert flush with in_valid=1 and out_ready=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0. The flushed input never appears.
- Stage empty, with main still holding a stale ctrl=4'b1001 → out_ctrl=0.
- Assert reset while FULL → outputs are all zero after the edge, in_ready=1.
- FLUSH_CLR_DATA=1 and flush with main holding 0x56789ABC → out_data=0. With FLUSH_CLR_DATA=0 the same flush leaves out_data=0x56789ABC.
